// File: rtl/pc_if.sv
// Bundles the program-counter control and result signals.
// master drives the enables and load data; slave is the counter itself.
interface pc_if #(
  parameter int N = 17
);
  logic         write_en;
  logic [N-1:0] datain;
  logic         inc_en;
  logic         clr_en;
  logic [N-1:0] dataout;
  logic         wrap;

  modport master (
    output write_en, datain, inc_en, clr_en,
    input  dataout, wrap
  );

  modport slave (
    input  write_en, datain, inc_en, clr_en,
    output dataout, wrap
  );
endinterface

// File: rtl/pc.sv
// N-bit program counter with clear/load/increment, in that priority order.
// Wrap pulses for one cycle after an increment that overflows.
module pc #(
  parameter int N    = 17,
  parameter int STEP = 1
) (
  input  logic clk,
  input  logic rst,
  pc_if.slave  bus
);

  localparam logic [N:0] STEP_EXT = (N+1)'(STEP);

  logic [N-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic [N:0]   sum;

  // One extra bit so the carry out becomes the wrap flag.
  assign sum = {1'b0, cnt_q} + STEP_EXT;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.clr_en) begin
      cnt_d = '0;
    end else if (bus.write_en) begin
      cnt_d = bus.datain;
    end else if (bus.inc_en) begin
      cnt_d  = sum[N-1:0];
      wrap_d = sum[N];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.dataout = cnt_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_pc.sv
// Directed bench for pc: stimulus pushes expected results, a monitor pops and compares.
module tb_pc;

  localparam int N = 17;

  typedef struct {
    string        name;
    logic [N-1:0] d;
    logic         w;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  exp_t exp_q[$];
  exp_t mon_e;

  pc_if #(.N(N)) bus ();

  pc #(.N(N), .STEP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Monitor: the counter presents a new result after every active edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk({mon_e.name, ".dataout"}, 32'(bus.dataout), 32'(mon_e.d));
      chk({mon_e.name, ".wrap"},    32'(bus.wrap),    32'(mon_e.w));
    end
  end

  task automatic step(input string nm, input logic c, input logic we, input logic inc,
                      input logic [N-1:0] din, input logic [N-1:0] ed, input logic ew);
    exp_t e;
    @(negedge clk);
    bus.clr_en   = c;
    bus.write_en = we;
    bus.inc_en   = inc;
    bus.datain   = din;
    e.name = nm;
    e.d    = ed;
    e.w    = ew;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst          = 1'b1;
    bus.clr_en   = 1'b0;
    bus.write_en = 1'b0;
    bus.inc_en   = 1'b0;
    bus.datain   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.dataout", 32'(bus.dataout), 0);
    chk("reset.wrap",    32'(bus.wrap),    0);
    @(negedge clk);
    rst = 1'b0;

    // idle after reset
    step("idle0", 0, 0, 0, 0, 0, 0);
    step("idle1", 0, 0, 0, 0, 0, 0);
    step("idle2", 0, 0, 0, 0, 0, 0);

    // load / increment / clear sequence
    step("load12", 0, 1, 0, 12, 12, 0);
    step("inc13",  0, 0, 1, 0,  13, 0);
    step("clr",    1, 0, 0, 0,  0,  0);

    // wrap-around at 2^17-1
    step("loadmax",  0, 1, 0, 17'h1FFFF, 17'h1FFFF, 0);
    step("incwrap",  0, 0, 1, 0,         0,         1);
    step("holdwrap", 0, 0, 0, 0,         0,         0);
    step("loadmax2", 0, 1, 0, 17'h1FFFF, 17'h1FFFF, 0);
    step("incwrap2", 0, 0, 1, 0,         0,         1);
    step("incnowrap",0, 0, 1, 0,         1,         0);

    // priority
    step("allthree", 1, 1, 1, 5, 0, 0);
    step("ldoverinc",0, 1, 1, 7, 7, 0);
    step("clroverld",1, 1, 0, 9, 0, 0);

    // level-sensitive increment and hold; datain ignored when not loading
    step("load100", 0, 1, 0, 100, 100, 0);
    step("inc101",  0, 0, 1, 0,   101, 0);
    step("inc102",  0, 0, 1, 0,   102, 0);
    step("inc103",  0, 0, 1, 0,   103, 0);
    step("inc104",  0, 0, 1, 0,   104, 0);
    step("hold0",   0, 0, 0, 999, 104, 0);
    step("hold1",   0, 0, 0, 555, 104, 0);

    // asynchronous reset between edges while incrementing
    step("load50", 0, 1, 0, 50, 50, 0);
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.inc_en   = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async.dataout", 32'(bus.dataout), 0);
    chk("async.wrap",    32'(bus.wrap),    0);
    repeat (2) @(posedge clk);
    #1;
    chk("inrst.dataout", 32'(bus.dataout), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.inc_en = 1'b0;
    step("postrst_hold", 0, 0, 0, 0, 0, 0);
    step("postrst_inc",  0, 0, 1, 0, 1, 0);
    step("final_hold",   0, 0, 0, 0, 1, 0);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
